ps2_rx_fifo: RTL
================

Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver. It replaces the single-byte keyboard receiver with a fully synchronous design clocked only by clk_50; ps2_clk is sampled, not used as a clock.
- Adds a glitch filter, odd-parity, stop-bit and timeout checking, and optional E0/F0 prefix folding.
- Adds an output FIFO with show-ahead read.
- Sits between the PS/2 pins and the keyboard/scancode consumer logic.

Parameters:
FILTER_LEN, 5, consecutive identical samples required before the filtered ps2_clk changes level (>=2)
TIMEOUT_CYCLES, 100000, clk_50 cycles without a bit strobe before an in-progress frame is abandoned (2 ms at 50 MHz)
FIFO_DEPTH, 8, entries in the output FIFO (power of two, >=2)
DECODE_PREFIX, 1, 1 = fold E0/F0 prefixes into the ext/brk flags; 0 = queue every byte raw

Ports:
clk_50  in  1  system clock; the only clock
areset  in  1  asynchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_dat  in  1  raw PS/2 data pin, asynchronous
rd_en  in  1  pop the FIFO head; ignored when valid_data=0
valid_data  out  1  FIFO non-empty; data/ext/brk are valid
data  out  8  scancode at the FIFO head
ext  out  1  head entry was preceded by E0
brk  out  1  head entry was preceded by F0
level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  out  1  one-cycle pulse: accepted entry dropped because FIFO full
parity_err  out  1  one-cycle pulse: parity mismatch
frame_err  out  1  one-cycle pulse: stop bit sampled 0
timeout_err  out  1  one-cycle pulse: frame abandoned on timeout

Behaviour:
- Reset (async, areset=1):
  - FSM goes to IDLE; bit count, timeout counter and prefix flags are cleared; FIFO is emptied.
  - Filter state and synchroniser flops reset to 1 (bus idle).
  - All outputs are 0. A reset mid-frame discards the partial frame.
- Input path:
  - Two-flop synchroniser on each pin.
  - Filtered clock takes the synchronised level only after FILTER_LEN consecutive equal samples.
- Strobe: one-cycle pulse on a 1->0 transition of the filtered clock. The synchronised ps2_dat is sampled in the strobe cycle.
- FSM, one transition per strobe:
  - IDLE: dat=0 -> DATA, bit count cleared. dat=1 -> stay.
  - DATA: shift in LSB first; after the 8th bit -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP: go to IDLE and evaluate the frame:
    - dat=0 -> frame_err (frame_err takes priority over parity).
    - Else, if the XOR of the 8 data bits and the parity bit is 0 -> parity_err.
    - Else the byte is accepted.
- Timeout:
  - Counter clears on every strobe and while in IDLE.
  - Outside IDLE, when the count reaches TIMEOUT_CYCLES-1: pulse timeout_err, go to IDLE, discard the partial frame.
- Any error or timeout also clears the ext/brk pending flags.
- Prefix decode, DECODE_PREFIX=1:
  - Accepted E0 sets ext_pend and is not queued; accepted F0 sets brk_pend and is not queued.
  - Any other byte is queued as {ext_pend, brk_pend, byte}, then both flags clear.
  - E0 F0 and F0 E0 orders are both legal.
- DECODE_PREFIX=0: every accepted byte is queued with ext=brk=0.
- Latency: accept result is registered, then the FIFO is written. valid_data rises exactly 2 cycles after the STOP strobe cycle when the FIFO was empty.
- FIFO:
  - Width 10, show-ahead: the head is visible while valid_data=1.
  - rd_en with valid_data=1 advances the head at the next edge.
- FIFO boundaries:
  - Push when full without a same-cycle pop -> entry dropped, overflow pulses, contents unchanged.
  - Push and pop in the same cycle -> both occur, level unchanged; this also applies when full.
  - rd_en when empty -> no effect.
  - Pointers wrap modulo FIFO_DEPTH; level counts 0..FIFO_DEPTH.

Decomposition:
- Package ps2_pkg:
  - FSM state typedef (IDLE, DATA, PARITY, STOP).
  - Constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0.
  - Odd-parity check function.
- One sub-module, sync_fifo: a generic show-ahead FIFO parametrised by WIDTH and DEPTH, with full, empty and level outputs, instantiated with WIDTH=10.
- Filter, FSM, timeout and prefix logic stay in ps2_rx_fifo.

Test Plan:
- Bench setup: half-bit period 50 cycles, TIMEOUT_CYCLES=2000, defaults otherwise.
- Frame 0x1C with parity 0, stop 1 -> valid_data 2 cycles after the stop strobe; data=0x1C, ext=0, brk=0, level=1; rd_en -> level=0.
- Frames E0, F0, 75 -> exactly one entry: data=0x75, ext=1, brk=1. A following frame 0x1C -> ext=0, brk=0.
- Frame 0x1C with parity 1 -> parity_err pulses once, level stays 0. Frame 0x1C with stop 0 -> frame_err only.
- Start bit + 4 data bits, then idle 2000 cycles -> timeout_err pulse. The next full frame 0x2A is received correctly.
- 9 frames 0x01..0x09 with no reads, FIFO_DEPTH=8 -> level=8, overflow pulses once on 0x09; reads return 0x01..0x08 in order.
- 2-cycle low glitch on ps2_clk with FILTER_LEN=5 -> no strobe, FSM stays IDLE, no error pulses.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types, byte constants and the parity helper for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones.
  function automatic logic ps2_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic show-ahead FIFO; head is visible combinationally while not empty, one-cycle push-to-visible.
// Push when full is dropped unless a pop happens in the same cycle; pop when empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign pop_dat_o = mem_q[rd_ptr_q];
  assign level_o   = cnt_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: sampled/filtered clock, frame checks, E0/F0 folding, show-ahead output FIFO.
// Entry visible 2 cycles after the stop-bit strobe; no backpressure to the device, full FIFO drops and pulses overflow.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 5,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8,
  parameter int DECODE_PREFIX  = 1
) (
  input  logic                        clk_50,
  input  logic                        areset,
  input  logic                        ps2_clk,
  input  logic                        ps2_dat,
  input  logic                        rd_en,
  output logic                        valid_data,
  output logic [7:0]                  data,
  output logic                        ext,
  output logic                        brk,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        timeout_err
);

  localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic filt_q, filt_d, filt_prev_q;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic strobe;

  ps2_state_e state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic       acc_vld_q, acc_vld_d;
  logic [7:0] acc_byte_q, acc_byte_d;
  logic       parity_err_q, parity_err_d;
  logic       frame_err_q, frame_err_d;
  logic       timeout_err_q, timeout_err_d;

  logic       ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic       overflow_q, overflow_d;
  logic       fifo_push, fifo_full, fifo_empty;
  logic [9:0] fifo_push_dat, fifo_head;

  // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (flt_cnt_q == FLT_LAST) begin
        filt_d = clk_s2_q;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  assign strobe = filt_prev_q & ~filt_q;

  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    shift_d       = shift_q;
    par_d         = par_q;
    tmo_d         = tmo_q + 1'b1;
    acc_vld_d     = 1'b0;
    acc_byte_d    = acc_byte_q;
    parity_err_d  = 1'b0;
    frame_err_d   = 1'b0;
    timeout_err_d = 1'b0;
    if (state_q == ST_IDLE) tmo_d = '0;
    if (strobe) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (!dat_s2_q) begin
            state_d  = ST_DATA;
            bitcnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = dat_s2_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!dat_s2_q) begin
            frame_err_d = 1'b1;
          end else if (!ps2_parity_ok(shift_q, par_q)) begin
            parity_err_d = 1'b1;
          end else begin
            acc_vld_d  = 1'b1;
            acc_byte_d = shift_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmo_q == TMO_LAST) begin
      timeout_err_d = 1'b1;
      state_d       = ST_IDLE;
      tmo_d         = '0;
    end
  end

  // Prefix folding runs one cycle after the stop strobe on the registered accept result.
  always_comb begin
    ext_pend_d    = ext_pend_q;
    brk_pend_d    = brk_pend_q;
    fifo_push     = 1'b0;
    fifo_push_dat = {ext_pend_q, brk_pend_q, acc_byte_q};
    if (parity_err_q || frame_err_q || timeout_err_q) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (acc_vld_q) begin
      if (DECODE_PREFIX != 0) begin
        if (acc_byte_q == PS2_PREFIX_EXT) begin
          ext_pend_d = 1'b1;
        end else if (acc_byte_q == PS2_PREFIX_BRK) begin
          brk_pend_d = 1'b1;
        end else begin
          fifo_push  = 1'b1;
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end
      end else begin
        fifo_push     = 1'b1;
        fifo_push_dat = {2'b00, acc_byte_q};
      end
    end
  end

  assign overflow_d = fifo_push & fifo_full & ~(rd_en & ~fifo_empty);

  always_ff @(posedge clk_50 or posedge areset) begin
    if (areset) begin
      clk_s1_q      <= 1'b1;
      clk_s2_q      <= 1'b1;
      dat_s1_q      <= 1'b1;
      dat_s2_q      <= 1'b1;
      filt_q        <= 1'b1;
      filt_prev_q   <= 1'b1;
      flt_cnt_q     <= '0;
      state_q       <= ST_IDLE;
      bitcnt_q      <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      tmo_q         <= '0;
      acc_vld_q     <= 1'b0;
      acc_byte_q    <= '0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      ext_pend_q    <= 1'b0;
      brk_pend_q    <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      clk_s1_q      <= ps2_clk;
      clk_s2_q      <= clk_s1_q;
      dat_s1_q      <= ps2_dat;
      dat_s2_q      <= dat_s1_q;
      filt_q        <= filt_d;
      filt_prev_q   <= filt_q;
      flt_cnt_q     <= flt_cnt_d;
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      tmo_q         <= tmo_d;
      acc_vld_q     <= acc_vld_d;
      acc_byte_q    <= acc_byte_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
      ext_pend_q    <= ext_pend_d;
      brk_pend_q    <= brk_pend_d;
      overflow_q    <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (10),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_50),
    .rst_i      (areset),
    .push_i     (fifo_push),
    .push_dat_i (fifo_push_dat),
    .pop_i      (rd_en),
    .pop_dat_o  (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (level)
  );

  // Head is masked while empty so outputs read 0 instead of stale storage.
  assign valid_data        = ~fifo_empty;
  assign {ext, brk, data}  = fifo_empty ? 10'd0 : fifo_head;
  assign overflow          = overflow_q;
  assign parity_err        = parity_err_q;
  assign frame_err         = frame_err_q;
  assign timeout_err       = timeout_err_q;

endmodule
